// File: rtl/bitserial_mac_seq_if.sv
// Handshake and multiplier-side signal bundle for bitserial_mac_seq.
// slave: the sequencer; master: scheduler, consumer and Mult_v2 around it.
interface bitserial_mac_seq_if #(
    parameter int WEIGHT_W = 16,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 24
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_neuron;
    logic [WEIGHT_W-1:0] in_weight;
    logic                in_last;
    logic                mult_enable;
    logic [DATA_W-1:0]   mult_neuron;
    logic                mult_weight_bit;
    logic [DATA_W-1:0]   mult_out;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    out_sum;
    logic                out_ovf;

    modport slave (
        input  in_valid, in_neuron, in_weight, in_last, mult_out, out_ready,
        output in_ready, mult_enable, mult_neuron, mult_weight_bit, out_valid, out_sum, out_ovf
    );

    modport master (
        output in_valid, in_neuron, in_weight, in_last, mult_out, out_ready,
        input  in_ready, mult_enable, mult_neuron, mult_weight_bit, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/bitserial_mac_seq.sv
// Bit-serial MAC sequencer: shifts weights LSB-first into Mult_v2 and accumulates per neuron.
// Build option SEQ_SAT_EN: saturating accumulator with sticky out_ovf (otherwise wraps, out_ovf=0).
//
// state   | meaning
// S_IDLE  | in_ready high, waiting for a term
// S_SHIFT | one weight bit per clock into Mult_v2
// S_WAIT  | MULT_LAT cycles for the product to settle
// S_ACCUM | add product to acc; enable drops at exit to clear Mult_v2
// S_DONE  | out_sum presented until out_ready
module bitserial_mac_seq #(
    parameter int WEIGHT_W = 16,
    parameter int DATA_W   = 16,
    parameter int MULT_LAT = 1,
    parameter int ACC_W    = 24
) (
    input  logic               clk,
    input  logic               reset,
    bitserial_mac_seq_if.slave bus
);
    localparam int BCW = (WEIGHT_W > 1) ? $clog2(WEIGHT_W) : 1;
    localparam int LCW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WAIT, S_ACCUM, S_DONE} state_t;

    state_t              r_state;
    logic [BCW-1:0]      r_bit_cnt;
    logic [LCW-1:0]      r_lat_cnt;
    logic [WEIGHT_W-1:0] r_weight;
    logic                r_last;
    logic [ACC_W-1:0]    r_acc;
    logic                r_in_ready;
    logic                r_mult_enable;
    logic [DATA_W-1:0]   r_mult_neuron;
    logic                r_mult_weight_bit;
    logic                r_out_valid;
    logic [ACC_W-1:0]    r_out_sum;
    logic [ACC_W-1:0]    w_acc_next;

`ifdef SEQ_SAT_EN
    logic                r_ovf;
    logic [ACC_W:0]      w_sum;
    logic                w_sat;

    // One guard bit: a sign mismatch between the top two bits means the add left the ACC_W range.
    assign w_sum      = (ACC_W+1)'($signed(r_acc)) + (ACC_W+1)'($signed(bus.mult_out));
    assign w_sat      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_next = !w_sat ? w_sum[ACC_W-1:0]
                      : (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
    assign bus.out_ovf = r_ovf;
`else
    assign w_acc_next  = r_acc + ACC_W'($signed(bus.mult_out));
    assign bus.out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_bit_cnt         <= '0;
            r_lat_cnt         <= '0;
            r_weight          <= '0;
            r_last            <= 1'b0;
            r_acc             <= '0;
            r_in_ready        <= 1'b1;
            r_mult_enable     <= 1'b0;
            r_mult_neuron     <= '0;
            r_mult_weight_bit <= 1'b0;
            r_out_valid       <= 1'b0;
            r_out_sum         <= '0;
`ifdef SEQ_SAT_EN
            r_ovf             <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mult_neuron     <= bus.in_neuron;
                        r_mult_weight_bit <= bus.in_weight[0];
                        r_weight          <= bus.in_weight >> 1;
                        r_last            <= bus.in_last;
                        r_bit_cnt         <= '0;
                        r_mult_enable     <= 1'b1;
                        r_in_ready        <= 1'b0;
                        r_state           <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BCW'(WEIGHT_W - 1)) begin
                        r_mult_weight_bit <= 1'b0;
                        if (MULT_LAT == 0) begin
                            r_state <= S_ACCUM;
                        end else begin
                            r_lat_cnt <= LCW'(MULT_LAT - 1);
                            r_state   <= S_WAIT;
                        end
                    end else begin
                        r_mult_weight_bit <= r_weight[0];
                        r_weight          <= r_weight >> 1;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= S_ACCUM;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_acc         <= w_acc_next;
                    r_mult_enable <= 1'b0;
`ifdef SEQ_SAT_EN
                    if (w_sat) begin
                        r_ovf <= 1'b1;
                    end
`endif
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_out_sum   <= w_acc_next;
                        r_state     <= S_DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_acc       <= '0;
                        r_out_valid <= 1'b0;
                        r_out_sum   <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
`ifdef SEQ_SAT_EN
                        r_ovf       <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready        = r_in_ready;
    assign bus.mult_enable     = r_mult_enable;
    assign bus.mult_neuron     = r_mult_neuron;
    assign bus.mult_weight_bit = r_mult_weight_bit;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_sum         = r_out_sum;
endmodule

// File: tb/tb_bitserial_mac_seq.sv
// Directed bench for bitserial_mac_seq with a behavioural Q8.8 Mult_v2 model (MULT_LAT=1).
// Second instance uses ACC_W=16 for the wrap/saturation case.
module tb_bitserial_mac_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    longint      acc0 = 0;
    longint      acc1 = 0;
    logic        ovf1 = 1'b0;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    bitserial_mac_seq_if                bus0();
    bitserial_mac_seq_if #(.ACC_W(16))  bus1();

    bitserial_mac_seq                dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    bitserial_mac_seq #(.ACC_W(16))  dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int prod(input logic [15:0] n, input logic [15:0] w);
        logic signed [31:0] p;
        p = $signed(n) * $signed(w);
        return int'($signed(p[23:8]));
    endfunction

    // Mult_v2 model: collects 16 bits while enabled, product valid one cycle after the last bit.
    int          m0_cnt = 0;
    logic [15:0] m0_w = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !bus0.mult_enable) begin
            m0_cnt = 0;
            m0_w = '0;
            bus0.mult_out <= '0;
        end else if (m0_cnt == 16) begin
            bus0.mult_out <= 16'(prod(bus0.mult_neuron, m0_w));
        end else begin
            m0_w[m0_cnt[3:0]] = bus0.mult_weight_bit;
            m0_cnt++;
        end
    end

    int          m1_cnt = 0;
    logic [15:0] m1_w = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !bus1.mult_enable) begin
            m1_cnt = 0;
            m1_w = '0;
            bus1.mult_out <= '0;
        end else if (m1_cnt == 16) begin
            bus1.mult_out <= 16'(prod(bus1.mult_neuron, m1_w));
        end else begin
            m1_w[m1_cnt[3:0]] = bus1.mult_weight_bit;
            m1_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 10000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model0(input logic [15:0] n, input logic [15:0] w, input logic l);
        acc0 += prod(n, w);
        if (l) begin
            exp0_q.push_back({8'd0, acc0[23:0]});
            acc0 = 0;
        end
    endtask

    task automatic send0(input logic [15:0] n, input logic [15:0] w, input logic l, output int hs);
        int t = 0;
        bus0.in_neuron = n;
        bus0.in_weight = w;
        bus0.in_last   = l;
        bus0.in_valid  = 1'b1;
        while (!bus0.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send0_ready", 32'(bus0.in_ready), 32'd1);
        hs = cyc;
        model0(n, w, l);
        @(negedge clk);
        bus0.in_valid  = 1'b0;
        bus0.in_neuron = 16'($urandom);
        bus0.in_weight = 16'($urandom);
    endtask

    task automatic gap0(output int lowc);
        int t = 0;
        lowc = 0;
        while (t < 40) begin
            if (!bus0.mult_enable) lowc++;
            if (bus0.in_ready) break;
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_out0(input string tag, input int hs, input int hold);
        int          t = 0;
        logic [31:0] e = '0;
        while (!bus0.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 32'(bus0.out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - hs), 32'd19);
        chk({tag, "_queue"}, 32'(exp0_q.size() > 0), 32'd1);
        if (exp0_q.size() > 0) e = exp0_q.pop_front();
        chk({tag, "_sum"}, 32'(bus0.out_sum), e);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus0.out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(bus0.out_sum), e);
            chk({tag, "_hold_in_ready"}, 32'(bus0.in_ready), 32'd0);
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus0.out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(bus0.in_ready), 32'd1);
    endtask

    task automatic send1(input logic [15:0] n, input logic [15:0] w, input logic l, output int hs);
        int     t = 0;
        longint s;
        bus1.in_neuron = n;
        bus1.in_weight = w;
        bus1.in_last   = l;
        bus1.in_valid  = 1'b1;
        while (!bus1.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send1_ready", 32'(bus1.in_ready), 32'd1);
        hs = cyc;
        s = acc1 + prod(n, w);
`ifdef SEQ_SAT_EN
        if (s > 32767) begin
            s = 32767;
            ovf1 = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            ovf1 = 1'b1;
        end
`else
        s = longint'($signed(s[15:0]));
`endif
        acc1 = s;
        if (l) begin
            exp1_q.push_back({15'd0, ovf1, s[15:0]});
            acc1 = 0;
            ovf1 = 1'b0;
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_out1(input string tag, input int hs);
        int          t = 0;
        logic [31:0] e = '0;
        while (!bus1.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 32'(bus1.out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - hs), 32'd19);
        chk({tag, "_queue"}, 32'(exp1_q.size() > 0), 32'd1);
        if (exp1_q.size() > 0) e = exp1_q.pop_front();
        chk({tag, "_sum"}, 32'(bus1.out_sum), {16'd0, e[15:0]});
        chk({tag, "_ovf"}, 32'(bus1.out_ovf), 32'(e[16]));
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus1.out_valid), 32'd0);
        chk({tag, "_ovf_clear"}, 32'(bus1.out_ovf), 32'd0);
    endtask

    initial begin
        int          hs;
        int          hs2;
        int          lowc;
        int          t;
        int          hs6[3];
        logic [15:0] bits;
        logic        en_all;
        logic [15:0] t6_n[3];
        logic [15:0] t6_w[3];

        t6_n[0] = 16'h0200; t6_w[0] = 16'h0180;
        t6_n[1] = 16'hFE00; t6_w[1] = 16'h0040;
        t6_n[2] = 16'h0123; t6_w[2] = 16'h0456;
        bus0.in_valid = 1'b0; bus0.in_neuron = '0; bus0.in_weight = '0; bus0.in_last = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_neuron = '0; bus1.in_weight = '0; bus1.in_last = 1'b0;
        bus1.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus0.out_sum), 32'd0);
        chk("rst_mult_enable", 32'(bus0.mult_enable), 32'd0);
        chk("rst_mult_neuron", 32'(bus0.mult_neuron), 32'd0);
        chk("rst_out_ovf", 32'(bus1.out_ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single term: weight bits land in SHIFT cycles 8 and 9.
        send0(16'h1001, 16'h0300, 1'b1, hs);
        bits = '0;
        en_all = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bits[k] = bus0.mult_weight_bit;
            en_all &= bus0.mult_enable;
            if (k < 15) @(negedge clk);
        end
        chk("t1_weight_bits", 32'(bits), 32'h0300);
        chk("t1_enable_shift", 32'(en_all), 32'd1);
        chk("t1_mult_neuron", 32'(bus0.mult_neuron), 32'h1001);
        wait_out0("t1", hs, 0);

        // Three terms back to back.
        send0(16'h0100, 16'h0200, 1'b0, hs);
        gap0(lowc);
        chk("t2_gap1", 32'(lowc), 32'd1);
        send0(16'h0100, 16'h0100, 1'b0, hs2);
        chk("t2_period", 32'(hs2 - hs), 32'd19);
        gap0(lowc);
        chk("t2_gap2", 32'(lowc), 32'd1);
        send0(16'hFF00, 16'h0100, 1'b1, hs);
        wait_out0("t2", hs, 0);

        // Consumer stalls in DONE, then acc must start clean.
        send0(16'h0200, 16'h0300, 1'b1, hs);
        wait_out0("t3", hs, 5);
        send0(16'h0100, 16'h0100, 1'b1, hs);
        wait_out0("t3b", hs, 0);

        // Reset in SHIFT cycle 5.
        send0(16'h1001, 16'h0300, 1'b1, hs);
        repeat (5) @(negedge clk);
        chk("t4_busy", 32'(bus0.mult_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("t4_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("t4_out_sum", 32'(bus0.out_sum), 32'd0);
        chk("t4_mult_enable", 32'(bus0.mult_enable), 32'd0);
        chk("t4_mult_bit", 32'(bus0.mult_weight_bit), 32'd0);
        chk("t4_mult_neuron", 32'(bus0.mult_neuron), 32'd0);
        exp0_q.delete();
        acc0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send0(16'h1001, 16'h0300, 1'b1, hs);
        wait_out0("t4", hs, 0);

        // Narrow accumulator: wrap or saturate depending on build.
        send1(16'h7000, 16'h0100, 1'b0, hs);
        send1(16'h7000, 16'h0100, 1'b1, hs);
        wait_out1("t5", hs);

        // in_valid held high; inputs scrambled while busy.
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (!bus0.in_ready && t < 40) begin
                bus0.in_neuron = 16'($urandom);
                bus0.in_weight = 16'($urandom);
                bus0.in_last   = 1'($urandom);
                @(negedge clk);
                t++;
            end
            chk("t6_ready", 32'(bus0.in_ready), 32'd1);
            bus0.in_neuron = t6_n[i];
            bus0.in_weight = t6_w[i];
            bus0.in_last   = (i == 2);
            hs6[i] = cyc;
            model0(t6_n[i], t6_w[i], (i == 2));
            @(negedge clk);
        end
        t = 0;
        while (!bus0.out_valid && t < 40) begin
            bus0.in_neuron = 16'($urandom);
            bus0.in_weight = 16'($urandom);
            bus0.in_last   = 1'($urandom);
            @(negedge clk);
            t++;
        end
        bus0.in_valid = 1'b0;
        chk("t6_period1", 32'(hs6[1] - hs6[0]), 32'd19);
        chk("t6_period2", 32'(hs6[2] - hs6[1]), 32'd19);
        wait_out0("t6", hs6[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
